// File: rtl/ppr_collector_rr.sv
// Per-channel PPR request queues with duplicate suppression and overflow flags,
// drained round-robin to a single valid/ready repair-engine port.
module ppr_collector_rr #(
  parameter int N_CH      = 32,
  parameter int ADDR_SIZE = 24,
  parameter int CH_WIDTH  = $clog2(N_CH),
  parameter int DEPTH     = 4,
  parameter int CNT_W     = $clog2(N_CH*DEPTH+1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CH-1:0]           ppr_valid_i,
  input  logic [2*N_CH-1:0]         ppr_type_i,
  input  logic [ADDR_SIZE*N_CH-1:0] ppr_addr_i,
  input  logic                      ppr_cmd_i,
  input  logic                      ppr_ready_i,
  output logic                      ppr_valid_o,
  output logic [1:0]                ppr_type_o,
  output logic [ADDR_SIZE-1:0]      ppr_addr_o,
  output logic [CH_WIDTH-1:0]       ppr_ch_o,
  output logic                      ppr_done_o,
  output logic [N_CH-1:0]           ppr_overflow_o,
  output logic [CNT_W-1:0]          ppr_pending_o
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int QCNT_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, ARB, OUT, DONE} state_t;
  state_t state, next_state;

  logic [1:0]           q_type [N_CH][DEPTH];
  logic [ADDR_SIZE-1:0] q_addr [N_CH][DEPTH];
  logic [DEPTH-1:0]     q_vld  [N_CH];
  logic [PTR_W-1:0]     head   [N_CH];
  logic [PTR_W-1:0]     tail   [N_CH];
  logic [QCNT_W-1:0]    count  [N_CH];
  logic [CH_WIDTH-1:0]  rr_ptr;

  logic [N_CH-1:0]     nonempty, full, dup, enq, drop_full;
  logic [CNT_W-1:0]    enq_total;
  logic                arb_found;
  logic [CH_WIDTH-1:0] arb_ch;
  logic                pop;

  // Slot valid bits let the duplicate check see exactly the queued entries,
  // including a head that is being popped this same cycle.
  always_comb begin
    enq_total = '0;
    for (int c = 0; c < N_CH; c++) begin
      nonempty[c] = (count[c] != '0);
      full[c]     = (count[c] == QCNT_W'(DEPTH));
      dup[c]      = 1'b0;
      for (int s = 0; s < DEPTH; s++) begin
        if (q_vld[c][s] &&
            q_type[c][s] == ppr_type_i[2*c +: 2] &&
            q_addr[c][s] == ppr_addr_i[ADDR_SIZE*c +: ADDR_SIZE])
          dup[c] = 1'b1;
      end
      enq[c]       = ppr_valid_i[c] && !dup[c] && !full[c];
      drop_full[c] = ppr_valid_i[c] && !dup[c] && full[c];
      enq_total    = enq_total + CNT_W'(enq[c]);
    end
  end

  always_comb begin
    arb_found = 1'b0;
    arb_ch    = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!arb_found && nonempty[(int'(rr_ptr) + i) % N_CH]) begin
        arb_found = 1'b1;
        arb_ch    = CH_WIDTH'((int'(rr_ptr) + i) % N_CH);
      end
    end
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: if (ppr_cmd_i) next_state = ARB;
      ARB: begin
        if (!ppr_cmd_i) begin
          next_state = IDLE;
        end else if (arb_found) begin
          pop        = 1'b1;
          next_state = OUT;
        end else begin
          next_state = DONE;
        end
      end
      OUT: if (ppr_ready_i) next_state = ppr_cmd_i ? ARB : IDLE;
      DONE: begin
        if (!ppr_cmd_i) next_state = IDLE;
        else if (|enq || |nonempty) next_state = ARB;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        q_vld[c] <= '0;
        head[c]  <= '0;
        tail[c]  <= '0;
        count[c] <= '0;
      end
      ppr_overflow_o <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (enq[c]) begin
          q_vld[c][tail[c]] <= 1'b1;
          tail[c]           <= tail[c] + PTR_W'(1);
        end
        if (drop_full[c]) ppr_overflow_o[c] <= 1'b1;
        if (pop && arb_ch == CH_WIDTH'(c)) begin
          q_vld[c][head[c]] <= 1'b0;
          head[c]           <= head[c] + PTR_W'(1);
        end
        count[c] <= count[c] + QCNT_W'(enq[c]) - QCNT_W'(pop && arb_ch == CH_WIDTH'(c));
      end
    end
  end

  // Payload storage needs no reset: the slot valid bits gate every use.
  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (enq[c]) begin
        q_type[c][tail[c]] <= ppr_type_i[2*c +: 2];
        q_addr[c][tail[c]] <= ppr_addr_i[ADDR_SIZE*c +: ADDR_SIZE];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      ppr_type_o    <= '0;
      ppr_addr_o    <= '0;
      ppr_ch_o      <= '0;
      ppr_pending_o <= '0;
    end else begin
      state         <= next_state;
      ppr_pending_o <= ppr_pending_o + enq_total - CNT_W'(pop);
      if (pop) begin
        ppr_type_o <= q_type[arb_ch][head[arb_ch]];
        ppr_addr_o <= q_addr[arb_ch][head[arb_ch]];
        ppr_ch_o   <= arb_ch;
      end
      if (state == OUT && ppr_ready_i)
        rr_ptr <= (ppr_ch_o == CH_WIDTH'(N_CH-1)) ? '0 : ppr_ch_o + CH_WIDTH'(1);
    end
  end

  assign ppr_valid_o = (state == OUT);
  assign ppr_done_o  = (state == DONE);

endmodule

// File: tb/tb_ppr_collector_rr.sv
// Self-checking bench for ppr_collector_rr: enqueue tables, drain scoreboard,
// and hand-written sequences for backpressure, late arrival and reset.
module tb_ppr_collector_rr;

  localparam int N_CH      = 32;
  localparam int ADDR_SIZE = 24;
  localparam int CH_WIDTH  = 5;
  localparam int CNT_W     = 8;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [N_CH-1:0]           valid_in;
  logic [2*N_CH-1:0]         type_in;
  logic [ADDR_SIZE*N_CH-1:0] addr_in;
  logic                      cmd, ready;
  logic                      ppr_valid_o, ppr_done_o;
  logic [1:0]                ppr_type_o;
  logic [ADDR_SIZE-1:0]      ppr_addr_o;
  logic [CH_WIDTH-1:0]       ppr_ch_o;
  logic [N_CH-1:0]           ppr_overflow_o;
  logic [CNT_W-1:0]          ppr_pending_o;

  ppr_collector_rr #(.N_CH(N_CH), .ADDR_SIZE(ADDR_SIZE), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ppr_valid_i(valid_in), .ppr_type_i(type_in), .ppr_addr_i(addr_in),
    .ppr_cmd_i(cmd), .ppr_ready_i(ready),
    .ppr_valid_o(ppr_valid_o), .ppr_type_o(ppr_type_o), .ppr_addr_o(ppr_addr_o),
    .ppr_ch_o(ppr_ch_o), .ppr_done_o(ppr_done_o),
    .ppr_overflow_o(ppr_overflow_o), .ppr_pending_o(ppr_pending_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  ch;
    logic [1:0]  typ;
    logic [23:0] addr;
  } out_t;

  typedef struct {
    int          ch;
    logic [1:0]  typ;
    logic [23:0] addr;
    int          exp_pend;
    logic        exp_ovf;
    logic        exp_out;
  } vec_t;

  out_t exp_q[$];
  vec_t vecs[6];
  int   out_count = 0;
  int   checks_total = 0;
  int   checks_passed = 0;
  int   base;

  task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Every accepted handshake is matched against the head of the scoreboard.
  always @(negedge clk) begin
    out_t got;
    out_t e;
    if (rst_n && ppr_valid_o && ready) begin
      out_count++;
      got.ch   = ppr_ch_o;
      got.typ  = ppr_type_o;
      got.addr = ppr_addr_o;
      if (exp_q.size() == 0) begin
        checks_total++;
        $display("[TB] FAIL unexpected_output: got 0x%0h, expected no output", got);
      end else begin
        e = exp_q.pop_front();
        checkOutput("output_entry", {33'd0, got}, {33'd0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(int ch, logic [1:0] typ, logic [23:0] addr);
    valid_in = '0;
    valid_in[ch] = 1'b1;
    type_in[2*ch +: 2] = typ;
    addr_in[ADDR_SIZE*ch +: ADDR_SIZE] = addr;
    tick();
    valid_in = '0;
  endtask

  task automatic push_exp(int ch, logic [1:0] typ, logic [23:0] addr);
    out_t e;
    e.ch   = ch[4:0];
    e.typ  = typ;
    e.addr = addr;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd   = 1'b0;
    ready = 1'b0;
    valid_in = '0;
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_done(int budget, string name);
    int i = 0;
    while (!ppr_done_o && i < budget) begin
      tick();
      i++;
    end
    checkOutput(name, 64'(ppr_done_o), 64'd1);
  endtask

  task automatic wait_valid(int budget, string name);
    int i = 0;
    while (!ppr_valid_o && i < budget) begin
      tick();
      i++;
    end
    checkOutput(name, 64'(ppr_valid_o), 64'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{2, 2'd1, 24'h000010, 1, 1'b0, 1'b1};
    vecs[1] = '{2, 2'd1, 24'h000010, 1, 1'b0, 1'b0};
    vecs[2] = '{2, 2'd1, 24'h000011, 2, 1'b0, 1'b1};
    vecs[3] = '{2, 2'd1, 24'h000012, 3, 1'b0, 1'b1};
    vecs[4] = '{2, 2'd1, 24'h000013, 4, 1'b0, 1'b1};
    vecs[5] = '{2, 2'd1, 24'h000014, 4, 1'b1, 1'b0};

    rst_n = 1'b0; cmd = 1'b0; ready = 1'b0;
    valid_in = '0; type_in = '0; addr_in = '0;
    repeat (2) tick();
    checkOutput("reset_valid", 64'(ppr_valid_o), 64'd0);
    checkOutput("reset_done", 64'(ppr_done_o), 64'd0);
    checkOutput("reset_pending", 64'(ppr_pending_o), 64'd0);
    checkOutput("reset_overflow", 64'(ppr_overflow_o), 64'd0);
    checkOutput("reset_payload", 64'({ppr_ch_o, ppr_type_o, ppr_addr_o}), 64'd0);

    $display("[TB] basic drain");
    do_reset();
    applyStimulus(0, 2'd1, 24'h000200);
    checkOutput("basic_pend1", 64'(ppr_pending_o), 64'd1);
    applyStimulus(5, 2'd2, 24'h000205);
    checkOutput("basic_pend2", 64'(ppr_pending_o), 64'd2);
    push_exp(0, 2'd1, 24'h000200);
    push_exp(5, 2'd2, 24'h000205);
    base = out_count;
    cmd = 1'b1; ready = 1'b1;
    tick();
    checkOutput("latency_arb_valid", 64'(ppr_valid_o), 64'd0);
    tick();
    checkOutput("latency_out_valid", 64'(ppr_valid_o), 64'd1);
    wait_done(40, "basic_done");
    checkOutput("basic_count", 64'(out_count - base), 64'd2);
    checkOutput("basic_pend0", 64'(ppr_pending_o), 64'd0);
    checkOutput("basic_sb_empty", 64'(exp_q.size()), 64'd0);
    cmd = 1'b0;
    tick();
    checkOutput("basic_done_clear", 64'(ppr_done_o), 64'd0);

    $display("[TB] round-robin fairness");
    do_reset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3, 2'd0, 24'(24'h000300 + i));
      applyStimulus(7, 2'd3, 24'(24'h000700 + i));
      push_exp(3, 2'd0, 24'(24'h000300 + i));
      push_exp(7, 2'd3, 24'(24'h000700 + i));
    end
    checkOutput("rr_pend6", 64'(ppr_pending_o), 64'd6);
    base = out_count;
    cmd = 1'b1; ready = 1'b1;
    wait_done(60, "rr_done");
    checkOutput("rr_count", 64'(out_count - base), 64'd6);
    checkOutput("rr_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] overflow and duplicate table");
    do_reset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].ch, vecs[i].typ, vecs[i].addr);
      checkOutput($sformatf("ovf_pend_%0d", i), 64'(ppr_pending_o), 64'(vecs[i].exp_pend));
      checkOutput($sformatf("ovf_flag_%0d", i), 64'(ppr_overflow_o),
                  vecs[i].exp_ovf ? 64'h4 : 64'h0);
      if (vecs[i].exp_out) push_exp(vecs[i].ch, vecs[i].typ, vecs[i].addr);
    end
    base = out_count;
    cmd = 1'b1; ready = 1'b1;
    wait_done(40, "ovf_done");
    checkOutput("ovf_count", 64'(out_count - base), 64'd4);
    checkOutput("ovf_sticky", 64'(ppr_overflow_o), 64'h4);
    checkOutput("ovf_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] backpressure");
    do_reset();
    applyStimulus(1, 2'd3, 24'h0000AA);
    push_exp(1, 2'd3, 24'h0000AA);
    base = out_count;
    cmd = 1'b1; ready = 1'b0;
    wait_valid(10, "bp_valid");
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("bp_hold_%0d", i),
                  64'({ppr_valid_o, ppr_ch_o, ppr_type_o, ppr_addr_o}),
                  64'({1'b1, 5'd1, 2'd3, 24'h0000AA}));
    end
    ready = 1'b1;
    tick();
    checkOutput("bp_valid_drop", 64'(ppr_valid_o), 64'd0);
    wait_done(20, "bp_done");
    checkOutput("bp_count", 64'(out_count - base), 64'd1);

    $display("[TB] late arrival and cmd drop");
    do_reset();
    ready = 1'b0; cmd = 1'b1;
    wait_done(10, "late_done_initial");
    base = out_count;
    applyStimulus(31, 2'd2, 24'hABCDEF);
    push_exp(31, 2'd2, 24'hABCDEF);
    checkOutput("late_done_drop", 64'(ppr_done_o), 64'd0);
    tick();
    checkOutput("late_valid", 64'({ppr_valid_o, ppr_ch_o, ppr_type_o, ppr_addr_o}),
                64'({1'b1, 5'd31, 2'd2, 24'hABCDEF}));
    cmd = 1'b0;
    tick();
    checkOutput("late_hold_cmd0", 64'(ppr_valid_o), 64'd1);
    ready = 1'b1;
    tick();
    checkOutput("late_idle_valid", 64'(ppr_valid_o), 64'd0);
    tick();
    checkOutput("late_idle_flags", 64'({ppr_valid_o, ppr_done_o}), 64'd0);
    checkOutput("late_count", 64'(out_count - base), 64'd1);
    checkOutput("late_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] reset mid-drain");
    do_reset();
    for (int c = 0; c < 7; c++) applyStimulus(c, 2'd1, 24'(24'h000600 + c));
    for (int k = 0; k < 5; k++) applyStimulus(12, 2'd2, 24'(24'h000C00 + k));
    checkOutput("rst_pend11", 64'(ppr_pending_o), 64'd11);
    checkOutput("rst_ovf_pre", 64'(ppr_overflow_o), 64'h1000);
    base = out_count;
    ready = 1'b0; cmd = 1'b1;
    tick();
    tick();
    checkOutput("rst_in_out", 64'({ppr_valid_o, ppr_pending_o}), 64'({1'b1, 8'd10}));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_valid", 64'(ppr_valid_o), 64'd0);
    checkOutput("rst_async_pending", 64'(ppr_pending_o), 64'd0);
    checkOutput("rst_async_ovf", 64'(ppr_overflow_o), 64'd0);
    checkOutput("rst_async_payload", 64'({ppr_ch_o, ppr_type_o, ppr_addr_o}), 64'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    ready = 1'b1;
    wait_done(10, "rst_then_done");
    checkOutput("rst_then_pending", 64'(ppr_pending_o), 64'd0);
    checkOutput("rst_then_count", 64'(out_count - base), 64'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
